fdiv_sched: RTL and testbench
=============================

Name: fdiv_sched

Overview:
- Shares one fixed-latency pipelined fdiv core among NREQ requesters.
- Round-robin arbitration issues at most one division per cycle into the core.
- A tag pipeline tracks each in-flight operation; each requester has one result holding register with a valid/ready handshake.
- Sits between the FPU issue logic of several cores/lanes and the single fdiv instance, which it instantiates internally.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, fdiv core latency in clock edges from operand sample to z registered; must equal the instantiated core's latency.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  operation of requester i accepted this cycle
- req_x  in  32*NREQ  dividend of requester i, bits [32i+31:32i], IEEE single
- req_y  in  32*NREQ  divisor of requester i, same packing
- resp_valid  out  NREQ  result held for requester i
- resp_ready  in  NREQ  requester i consumes its result
- resp_z  out  32*NREQ  quotient for requester i, same packing
- busy  out  1  any operation in flight or any resp_valid set

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On rst, clear: pend, tag pipeline valids/ids, RR pointer (0), resp_valid (0), resp_z (0).
  - req_ready is forced 0 while rst is high. busy is 0 the cycle after rst.
- pend[i]: set on the issue edge of requester i; cleared on the edge where resp_valid[i] && resp_ready[i].
  - Guarantees at most one outstanding operation per requester, so the result register can never overflow.
- Eligibility: elig[i] = req_valid[i] && (!pend[i] || (resp_valid[i] && resp_ready[i])). A same-cycle consume lets a new issue proceed.
- Arbitration (combinational):
  - Scan from ptr, ptr+1 ... ptr+NREQ-1, wrapping mod NREQ; the first eligible index gets the grant.
  - req_ready = one-hot grant; all zeros if nothing is eligible.
  - req_ready may depend on req_valid; requesters must not depend on req_ready to assert valid.
- On a grant to g:
  - Drive req_x[g]/req_y[g] to the core in the same cycle.
  - Push {valid=1, id=g} into stage 0 of the LAT-deep tag shift register.
  - ptr <= (g+1) mod NREQ.
  - With no grant, push valid=0 and leave ptr unchanged.
- With no grant, core operands are driven to 0. The core has no stall; bubbles are harmless.
- Completion:
  - When the tag at stage LAT-1 is valid, core z is valid in that same cycle.
  - On that edge: resp_z[id] <= z and resp_valid[id] <= 1.
- Latency: issue in cycle t gives resp_valid visible in cycle t+LAT+1 (4 by default).
- Throughput: the core accepts 1 op/cycle in aggregate; a single requester achieves 1 op per LAT+1 cycles with immediate consume.
- resp_valid[i] and resp_z[i] stay stable until consumed. Completion into a held register cannot occur because pend prevents it.
  - Simulation assertion: completion with resp_valid[id]=1 and no same-edge consume is an error.
  - A same-edge consume plus completion for the same id is impossible by construction.
- Arithmetic: no checking or special-casing. Zero divisor, NaN, inf and denormals pass through with the core's behaviour.
- Reset mid-operation: all in-flight ops are discarded, no late responses appear, and the core's own rst is tied to rst.
- busy = OR(tag valids) | OR(resp_valid).

Test Plan:
- Single op:
  - Stimulus: requester 0, x=0x40400000, y=0x3F800000, valid in cycle 0.
  - Required: req_ready[0]=1 in cycle 0; resp_valid[0]=1 in cycle 4; resp_z equals the standalone core output for the same operands (within 1 ulp of 0x40400000); held until resp_ready.
- Contention:
  - Stimulus: requesters 0 and 2 valid in cycle 0, ptr=0.
  - Required: grant 0 in cycle 0 and 2 in cycle 1; responses in cycles 4 and 5; ptr ends at 3.
- Fairness:
  - Stimulus: all 4 valid continuously, resp_ready=1.
  - Required: grant sequence is 0,1,2,3,0,1,... with no requester granted twice within any 4 consecutive grants.
- Backpressure:
  - Stimulus: resp_ready[1]=0 after requester 1 completes.
  - Required: req_ready[1] stays 0 despite req_valid[1]=1 while others keep issuing.
  - Then raise resp_ready[1]: consume and the new issue occur in the same cycle.
- Reset mid-flight:
  - Stimulus: 3 ops issued in cycles 0-2, rst asserted in cycle 3.
  - Required: no resp_valid ever rises for them; busy=0 from cycle 4; a new op after reset completes normally at issue+4.

Source files
------------

// File: rtl/fdiv_sched.sv
// fdiv_core: single-precision divider, round-to-nearest-even, denormals flushed to zero.
// z is registered on the third edge after x/y are sampled and a new operation is accepted every cycle.
module fdiv_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] z
);
    localparam logic [1:0] CLS_NUM  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic [31:0]       x_q, y_q;
    logic              s_q, s_d;
    logic [1:0]        cls_q, cls_d;
    logic signed [9:0] e_q, e_d;
    logic [25:0]       q_q, q_d;
    logic              st_q, st_d;
    logic [31:0]       z_q, z_d;

    logic [48:0]       num, den;
    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

    // quotient of the two 1.m mantissas, scaled so that it lands in [2^24, 2^26)
    always_comb begin
        x_zero = (x_q[30:23] == 8'd0);
        y_zero = (y_q[30:23] == 8'd0);
        x_inf  = (x_q[30:23] == 8'hff) && (x_q[22:0] == 23'd0);
        y_inf  = (y_q[30:23] == 8'hff) && (y_q[22:0] == 23'd0);
        x_nan  = (x_q[30:23] == 8'hff) && (x_q[22:0] != 23'd0);
        y_nan  = (y_q[30:23] == 8'hff) && (y_q[22:0] != 23'd0);
        num    = {1'b1, x_q[22:0], 25'd0};
        den    = {25'd0, 1'b1, y_q[22:0]};
        q_d    = 26'(num / den);
        st_d   = (num % den) != 49'd0;
        s_d    = x_q[31] ^ y_q[31];
        e_d    = $signed({2'b00, x_q[30:23]}) - $signed({2'b00, y_q[30:23]}) + 10'sd127;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf))
            cls_d = CLS_NAN;
        else if (x_inf || y_zero)
            cls_d = CLS_INF;
        else if (x_zero || y_inf)
            cls_d = CLS_ZERO;
        else
            cls_d = CLS_NUM;
    end

    logic [22:0]       frac, frac_r;
    logic              grd, stk, up, carry;
    logic signed [9:0] e_n;

    always_comb begin
        if (q_q[25]) begin
            frac = q_q[24:2];
            grd  = q_q[1];
            stk  = q_q[0] | st_q;
            e_n  = e_q;
        end else begin
            frac = q_q[23:1];
            grd  = q_q[0];
            stk  = st_q;
            e_n  = e_q - 10'sd1;
        end
        up              = grd & (stk | frac[0]);
        {carry, frac_r} = {1'b0, frac} + {23'd0, up};
        if (carry)
            e_n = e_n + 10'sd1;
        case (cls_q)
            CLS_NAN:  z_d = 32'h7fc0_0000;
            CLS_INF:  z_d = {s_q, 8'hff, 23'd0};
            CLS_ZERO: z_d = {s_q, 31'd0};
            default: begin
                if (e_n >= 10'sd255)
                    z_d = {s_q, 8'hff, 23'd0};
                else if (e_n <= 10'sd0)
                    z_d = {s_q, 31'd0};
                else
                    z_d = {s_q, e_n[7:0], frac_r};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            s_q   <= 1'b0;
            cls_q <= CLS_ZERO;
            e_q   <= '0;
            q_q   <= '0;
            st_q  <= 1'b0;
            z_q   <= '0;
        end else begin
            x_q   <= x;
            y_q   <= y;
            s_q   <= s_d;
            cls_q <= cls_d;
            e_q   <= e_d;
            q_q   <= q_d;
            st_q  <= st_d;
            z_q   <= z_d;
        end
    end

    assign z = z_q;
endmodule

// fdiv_sched: round-robin sharing of one pipelined fdiv_core among NREQ requesters; resp_valid
// appears LAT+1 cycles after issue and a requester is not re-granted until its held result is consumed.
module fdiv_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [32*NREQ-1:0]   resp_z,
    output logic                 busy
);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]    pend_q, pend_d;
    logic [LAT-1:0]     tag_vld_q, tag_vld_d;
    logic [PW-1:0]      tag_id_q [LAT];
    logic [PW-1:0]      tag_id_d [LAT];
    logic [NREQ-1:0]    resp_valid_q, resp_valid_d;
    logic [32*NREQ-1:0] resp_z_q, resp_z_d;

    logic [NREQ-1:0]    cons, elig, gnt_vec;
    logic               gnt_any;
    logic [PW-1:0]      gnt_id, scan_id;
    logic [31:0]        op_x, op_y, core_z;
    logic               comp_vld, comp_clash;
    logic [PW-1:0]      comp_id;

    always_comb begin
        cons    = resp_valid_q & resp_ready;
        elig    = req_valid & (~pend_q | cons);
        gnt_any = 1'b0;
        gnt_id  = '0;
        scan_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_id = PW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_any && elig[scan_id]) begin
                gnt_any = 1'b1;
                gnt_id  = scan_id;
            end
        end
        gnt_vec = '0;
        if (gnt_any)
            gnt_vec[gnt_id] = 1'b1;

        op_x = '0;
        op_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) begin
                op_x = req_x[32*i +: 32];
                op_y = req_y[32*i +: 32];
            end
        end

        ptr_d       = gnt_any ? PW'((int'(gnt_id) + 1) % NREQ) : ptr_q;
        pend_d      = (pend_q & ~cons) | gnt_vec;
        tag_vld_d   = {tag_vld_q[LAT-2:0], gnt_any};
        tag_id_d[0] = gnt_id;
        for (int k = 1; k < LAT; k++)
            tag_id_d[k] = tag_id_q[k-1];

        // the tag leaving the last stage lines up with core_z of the same operation
        comp_vld     = tag_vld_q[LAT-1];
        comp_id      = tag_id_q[LAT-1];
        comp_clash   = comp_vld && resp_valid_q[comp_id] && !resp_ready[comp_id];
        resp_valid_d = resp_valid_q & ~cons;
        resp_z_d     = resp_z_q;
        for (int i = 0; i < NREQ; i++) begin
            if (comp_vld && comp_id == PW'(i)) begin
                resp_valid_d[i]      = 1'b1;
                resp_z_d[32*i +: 32] = core_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            pend_q       <= '0;
            tag_vld_q    <= '0;
            resp_valid_q <= '0;
            resp_z_q     <= '0;
            for (int k = 0; k < LAT; k++)
                tag_id_q[k] <= '0;
        end else begin
            ptr_q        <= ptr_d;
            pend_q       <= pend_d;
            tag_vld_q    <= tag_vld_d;
            resp_valid_q <= resp_valid_d;
            resp_z_q     <= resp_z_d;
            for (int k = 0; k < LAT; k++)
                tag_id_q[k] <= tag_id_d[k];
        end
    end

    // LAT must match the three register stages of fdiv_core
    fdiv_core u_core (
        .clk (clk),
        .rst (rst),
        .x   (op_x),
        .y   (op_y),
        .z   (core_z)
    );

    assert property (@(posedge clk) disable iff (rst) !comp_clash);

    assign req_ready  = rst ? '0 : gnt_vec;
    assign resp_valid = resp_valid_q;
    assign resp_z     = resp_z_q;
    assign busy       = (|tag_vld_q) | (|resp_valid_q);
endmodule

// File: tb/tb_fdiv_sched.sv
// Bench for fdiv_sched: cycle-level reference model of grants, pend state and result timing,
// with quotients checked against real-valued division to within one ulp.
module tb_fdiv_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_x = '0;
    logic [32*NREQ-1:0]   req_y = '0;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready = '0;
    logic [32*NREQ-1:0]   resp_z;
    logic                 busy;

    always #5 clk = ~clk;

    fdiv_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          id;
        logic [31:0] x;
        logic [31:0] y;
        int          due;
    } op_t;

    op_t         fly [$];
    int          cyc   = 0;
    int          m_ptr = 0;
    bit          m_pend [NREQ];
    bit          m_rv   [NREQ];
    logic [31:0] m_x    [NREQ];
    logic [31:0] m_y    [NREQ];
    logic [31:0] op_x   [NREQ];
    logic [31:0] op_y   [NREQ];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) for (int k = 0; k < e; k++) p = p * 2.0;
        else        for (int k = 0; k < -e; k++) p = p / 2.0;
        return p;
    endfunction

    function automatic real f2r(input logic [31:0] b);
        real m;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
        return b[31] ? -m : m;
    endfunction

    function automatic bit z_ok(input logic [31:0] z, input logic [31:0] x, input logic [31:0] y);
        real q, d;
        if (z[30:23] == 8'd0 || z[30:23] == 8'hff) return 1'b0;
        q = f2r(x) / f2r(y);
        d = f2r(z) - q;
        if (d < 0.0) d = -d;
        return d <= pow2(int'(z[30:23]) - 150);
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [31:0] b;
        b[31]    = 1'($urandom_range(0, 1));
        b[30:23] = 8'($urandom_range(100, 154));
        b[22:0]  = 23'($urandom);
        return b;
    endfunction

    task automatic rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_x[i] = rnd_f();
            op_y[i] = rnd_f();
        end
    endtask

    // one clock cycle: drive, check against the model, then advance the model over the edge
    task automatic step(input logic r, input logic [NREQ-1:0] v, input logic [NREQ-1:0] rr);
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        logic            exp_busy;
        op_t             o;
        rst        = r;
        req_valid  = v;
        resp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_x[32*i +: 32] = op_x[i];
            req_y[32*i +: 32] = op_y[i];
        end
        #1;
        g = -1;
        if (!r) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && v[idx] && (!m_pend[idx] || (m_rv[idx] && rr[idx])))
                    g = idx;
            end
        end
        exp_rdy  = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_busy = (fly.size() != 0);
        for (int i = 0; i < NREQ; i++) begin
            exp_rv[i] = m_rv[i];
            exp_busy  = exp_busy | m_rv[i];
        end
        chk($sformatf("req_ready@%0d", cyc), 32'(req_ready), 32'(exp_rdy));
        chk($sformatf("resp_valid@%0d", cyc), 32'(resp_valid), 32'(exp_rv));
        chk($sformatf("busy@%0d", cyc), 32'(busy), 32'(exp_busy));
        for (int i = 0; i < NREQ; i++) begin
            if (m_rv[i])
                chk($sformatf("z%0d@%0d %h/%h=%h within 1ulp", i, cyc, m_x[i], m_y[i],
                              resp_z[32*i +: 32]),
                    32'(z_ok(resp_z[32*i +: 32], m_x[i], m_y[i])), 32'd1);
        end

        @(posedge clk);
        if (r) begin
            fly.delete();
            m_ptr = 0;
            for (int i = 0; i < NREQ; i++) begin
                m_pend[i] = 1'b0;
                m_rv[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_rv[i] && rr[i]) begin
                    m_rv[i]   = 1'b0;
                    m_pend[i] = 1'b0;
                end
            end
            for (int j = fly.size() - 1; j >= 0; j--) begin
                if (fly[j].due == cyc + 1) begin
                    m_rv[fly[j].id] = 1'b1;
                    m_x[fly[j].id]  = fly[j].x;
                    m_y[fly[j].id]  = fly[j].y;
                    fly.delete(j);
                end
            end
            if (g >= 0) begin
                m_pend[g] = 1'b1;
                o.id  = g;
                o.x   = op_x[g];
                o.y   = op_y[g];
                o.due = cyc + LAT + 1;
                fly.push_back(o);
                m_ptr = (g + 1) % NREQ;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            m_pend[i] = 1'b0;
            m_rv[i]   = 1'b0;
            m_x[i]    = '0;
            m_y[i]    = '0;
        end
        @(posedge clk);
        @(negedge clk);

        // reset held with all requesters asking: nothing may be accepted
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);

        // single op 3.0 / 1.0, result held while not consumed
        op_x[0] = 32'h4040_0000;
        op_y[0] = 32'h3f80_0000;
        step(1'b0, 4'b0001, 4'b0000);
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000);

        // contention between requesters 0 and 2 from ptr = 0
        step(1'b1, 4'b0000, 4'b0000);
        rnd_ops();
        step(1'b0, 4'b0101, 4'b1111);
        step(1'b0, 4'b0100, 4'b1111);
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0000, 4'b1111);

        // fairness with everyone always valid, then requester 1 backpressured
        step(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            rnd_ops();
            step(1'b0, 4'b1111, 4'b1111);
        end
        for (int k = 0; k < 12; k++) begin
            rnd_ops();
            step(1'b0, 4'b1111, 4'b1101);
        end
        for (int k = 0; k < 8; k++) begin
            rnd_ops();
            step(1'b0, 4'b1111, 4'b1111);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0000, 4'b1111);

        // reset with three ops in flight, then a fresh op
        step(1'b1, 4'b0000, 4'b0000);
        rnd_ops();
        step(1'b0, 4'b0001, 4'b0000);
        step(1'b0, 4'b0010, 4'b0000);
        step(1'b0, 4'b0100, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        for (int k = 0; k < 6; k++) step(1'b0, 4'b0000, 4'b0000);
        rnd_ops();
        step(1'b0, 4'b1000, 4'b0000);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b1111);

        // random traffic with occasional reset
        for (int k = 0; k < 2500; k++) begin
            rnd_ops();
            step(1'($urandom_range(0, 299) == 0), 4'($urandom),
                 4'($urandom) | 4'($urandom));
        end
        for (int k = 0; k < 8; k++) step(1'b0, 4'b0000, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
